// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Front end of the 16-bit core. Fetches the contiguous word
//                range [start_addr..end_addr] (inclusive, wrapping through
//                2^ADDR_W-1 -> 0) from a synchronous-read instruction memory.
//                Fetched words go into a small prefetch FIFO, and the FIFO
//                head is issued to the core at up to one instruction per
//                clock. The core cannot stall, so every cycle with
//                instr_valid=1 pops the FIFO.
//  Ports       : clock, reset_n (async, active low)
//                start, start_addr, end_addr : launch a program (IDLE only)
//                hold                        : suppress issue, FIFO retained
//                imem_req/imem_addr/imem_rdata : memory read port, 1-cycle
//                                                read latency
//                instr_valid/instr           : issue to core
//                busy (FETCH or DRAIN), done (pulse with final issue)
//                issue_count                 : only with IFU_PERF_EN
//  Options     : `define IFU_PERF_EN adds issue_count[15:0], a saturating
//                count of issue cycles, cleared on reset and accepted start.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              hold,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic              instr_valid,
    output logic [15:0]       instr,
    output logic              busy,
    output logic              done
`ifdef IFU_PERF_EN
    ,
    output logic [15:0]       issue_count
`endif
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE   = {{(c_CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_last;
    logic                r_inflight;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [15:0]         r_fifo [FIFO_DEPTH];

    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_done;
    logic [c_CNT_W-1:0]  w_credit;

    // A word is pushed on the edge after its request, so the outstanding
    // request reserves a FIFO slot. Holding count+inflight below the depth
    // makes overflow impossible even with hold asserted.
    assign w_empty  = (r_count == '0);
    assign w_push   = r_inflight;
    assign w_credit = r_count + {{(c_CNT_W-1){1'b0}}, r_inflight};

    assign imem_req    = (r_state == S_FETCH) && (w_credit < c_DEPTH);
    assign imem_addr   = r_pc;
    assign instr_valid = !w_empty && !hold;
    assign w_pop       = instr_valid;
    assign instr       = w_empty ? 16'h0000 : r_fifo[r_rd_ptr];
    assign busy        = (r_state != S_IDLE);
    assign done        = w_done;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_req && (r_pc == r_last)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave on the edge of the final pop so busy drops in the
                // cycle right after done.
                if (!r_inflight && (r_count == c_ONE) && w_pop) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end else if (!r_inflight && w_empty) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Address generation and outstanding-request tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc       <= '0;
            r_last     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= imem_req;
            if ((r_state == S_IDLE) && start) begin
                r_pc   <= start_addr;
                r_last <= end_addr;
            end else if (imem_req) begin
                r_pc <= r_pc + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefetch FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible when count covers them.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= imem_rdata;
        end
    end

`ifdef IFU_PERF_EN
    // ------------------------------------------------------------------
    // Issue-cycle counter, saturating
    // ------------------------------------------------------------------
    logic [15:0] r_issue_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_issue_count <= 16'h0000;
        end else if ((r_state == S_IDLE) && start) begin
            r_issue_count <= 16'h0000;
        end else if (instr_valid && (r_issue_count != 16'hFFFF)) begin
            r_issue_count <= r_issue_count + 16'h0001;
        end
    end

    assign issue_count = r_issue_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Directed, table-driven bench for instr_fetch_unit. Each
//                table row launches one program and checks request
//                addresses, issued words, latency, gaps, done and busy.
//                Hand-written sequences cover reset state and async reset
//                in mid-fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int ADDR_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int NVEC       = 8;
    localparam int BUDGET     = 80;

    logic              clock;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic              hold;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_rdata;
    logic              instr_valid;
    logic [15:0]       instr;
    logic              busy;
    logic              done;
`ifdef IFU_PERF_EN
    logic [15:0]       issue_count;
`endif

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [256];

    instr_fetch_unit #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
        .hold        (hold),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .busy        (busy),
        .done        (done)
`ifdef IFU_PERF_EN
        ,
        .issue_count (issue_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read instruction memory, one cycle latency.
    always @(posedge clock) begin
        if (imem_req) begin
            imem_rdata <= mem[imem_addr];
        end
    end

    typedef struct {
        logic [7:0] sa;
        logic [7:0] ea;
        int         hold_cyc;    // hold=1 during cycles 1..hold_cyc after start
        int         n;           // words in the program
        int         first_cyc;   // cycle of first instr_valid (cycle 1 = after start edge)
        int         hold_reqs;   // requests issued by the end of the hold window
        int         restart_cyc; // cycle in which a stray start is pulsed (0 = none)
    } vec_t;

    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int         reqs;
        int         nis;
        int         first;
        int         gaps;
        bit         done_seen;
        bit         prev_done;
        bit         finished;
        logic [7:0] a;
        reqs = 0; nis = 0; first = -1; gaps = 0;
        done_seen = 0; prev_done = 0; finished = 0;

        @(negedge clock);
        start      = 1'b1;
        start_addr = v.sa;
        end_addr   = v.ea;
        hold       = (v.hold_cyc > 0);
        @(negedge clock);
        start = 1'b0;
        for (int cyc = 1; cyc <= BUDGET && !finished; cyc++) begin
            hold = (cyc <= v.hold_cyc);
            if (cyc == v.restart_cyc) begin
                start      = 1'b1;
                start_addr = 8'h80;
                end_addr   = 8'h80;
            end else begin
                start = 1'b0;
            end
            #1;
            if (prev_done) begin
                chk("busy_after_done", {31'd0, busy}, 32'd0);
                finished = 1;
            end else begin
                if (imem_req) begin
                    a = v.sa + reqs[7:0];
                    chk("imem_addr", {24'd0, imem_addr}, {24'd0, a});
                    reqs++;
                end
                if (instr_valid) begin
                    a = v.sa + nis[7:0];
                    chk("instr", {16'd0, instr}, {16'd0, mem[a]});
                    if (first < 0) first = cyc;
                    nis++;
                end else if (first >= 0 && nis < v.n && cyc > v.hold_cyc) begin
                    gaps++;
                end
                if (done) begin
                    done_seen = 1;
                    chk("done_with_last", nis, v.n);
                    chk("done_valid", {31'd0, instr_valid}, 32'd1);
                end
                prev_done = done;
                if (cyc == v.hold_cyc) begin
                    chk("hold_reqs", reqs, v.hold_reqs);
                    if (v.hold_reqs == FIFO_DEPTH) begin
                        chk("hold_req_stalled", {31'd0, imem_req}, 32'd0);
                    end
                end
            end
            @(negedge clock);
        end
        chk("run_finished", {31'd0, finished}, 32'd1);
        chk("req_count", reqs, v.n);
        chk("issue_total", nis, v.n);
        chk("first_valid_cycle", first, v.first_cyc);
        chk("gaps", gaps, 0);
        chk("done_seen", {31'd0, done_seen}, 32'd1);
`ifdef IFU_PERF_EN
        chk("issue_count", {16'd0, issue_count}, v.n);
`endif
    endtask

    initial begin
        vec_t vr;

        for (int i = 0; i < 256; i++) begin
            mem[i] = {~i[7:0], i[7:0]};
        end
        mem[0] = 16'h911e;
        mem[1] = 16'h9201;
        mem[2] = 16'h0314;

        //          sa     ea     hold n   first hreq restart
        vecs[0] = '{8'h00, 8'h02, 0,   3,  3,    0,   0};  // basic 3-word program
        vecs[1] = '{8'h05, 8'h05, 0,   1,  3,    0,   0};  // single word
        vecs[2] = '{8'hFE, 8'h01, 0,   4,  3,    0,   0};  // address wrap
        vecs[3] = '{8'h00, 8'h09, 10,  10, 11,   4,   0};  // hold fills FIFO
        vecs[4] = '{8'h10, 8'h1F, 0,   16, 3,    0,   0};  // steady streaming
        vecs[5] = '{8'h20, 8'h27, 3,   8,  4,    3,   0};  // short hold
        vecs[6] = '{8'h30, 8'h37, 0,   8,  3,    0,   2};  // stray start while busy
        vecs[7] = '{8'h00, 8'h02, 0,   3,  3,    0,   0};  // repeat, counter cleared

        reset_n    = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        end_addr   = '0;
        hold       = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_instr", {16'd0, instr}, 32'd0);
`ifdef IFU_PERF_EN
        chk("rst_issue_count", {16'd0, issue_count}, 32'd0);
`endif
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i]);
        end

        // Asynchronous reset while fetching.
        @(negedge clock);
        start      = 1'b1;
        start_addr = 8'h40;
        end_addr   = 8'h4F;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("pre_reset_valid", {31'd0, instr_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_req", {31'd0, imem_req}, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        vr = '{8'h40, 8'h4F, 0, 16, 3, 0, 0};
        run_vec(vr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
